// File: rtl/isp_div_seq.sv
// rtl/isp_div_seq.sv - sequential restoring divider, one quotient bit per cycle
module isp_div_seq #(
  parameter int WIDTH = 36
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] quot,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] den_q;
  logic [WIDTH-1:0] shf_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic [WIDTH:0]   trial;
  logic             fits;

  // Next partial remainder: shift in the next numerator bit, MSB first.
  always_comb begin
    trial = {rem_q, shf_q[WIDTH-1]};
    fits  = (trial >= {1'b0, den_q});
  end

  // Load on start (restarting any run in flight), then one restoring step per cycle.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      den_q <= '0;
      shf_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= '0;
        den_q <= den;
        shf_q <= num;
        cnt_q <= CW'(WIDTH);
        run_q <= 1'b1;
      end else if (run_q) begin
        if (fits) begin
          rem_q <= WIDTH'(trial - {1'b0, den_q});
          shf_q <= {shf_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= trial[WIDTH-1:0];
          shf_q <= {shf_q[WIDTH-2:0], 1'b0};
        end
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign quot = shf_q;

endmodule

// File: rtl/isp_awb_gain.sv
// rtl/isp_awb_gain.sv - gray-world R/B white-balance gain computation
module isp_awb_gain #(
  parameter int OUT_BITS  = 32,
  parameter int GAIN_BITS = 8,
  parameter int GAIN_FRAC = 4,
  parameter int MIN_CNT   = 1024
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 in_done,
  input  logic [OUT_BITS-1:0]  in_cnt,
  input  logic [OUT_BITS-1:0]  in_sum_r,
  input  logic [OUT_BITS-1:0]  in_sum_g,
  input  logic [OUT_BITS-1:0]  in_sum_b,
  output logic [GAIN_BITS-1:0] out_gain_r,
  output logic [GAIN_BITS-1:0] out_gain_b,
  output logic                 out_valid,
  output logic                 out_skip,
  output logic                 busy
);

  localparam int N = OUT_BITS + GAIN_FRAC;
  localparam logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(1 << GAIN_FRAC);

  typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, UPDATE} state_t;

  state_t state, state_nxt;

  logic [OUT_BITS-1:0]  hold_cnt;
  logic [OUT_BITS-1:0]  hold_r;
  logic [OUT_BITS-1:0]  hold_g;
  logic [OUT_BITS-1:0]  hold_b;
  logic [GAIN_BITS-1:0] new_gain_r;
  logic [GAIN_BITS-1:0] new_gain_b;
  logic                 div_kick;
  logic                 div_start;
  logic [N-1:0]         div_num;
  logic [N-1:0]         div_den;
  logic [N-1:0]         div_quot;
  logic                 div_done;
  logic                 accept;

  // Zero divisor means no information for that channel, so fall back to unity;
  // otherwise floor quotient clipped to the largest representable gain.
  function automatic logic [GAIN_BITS-1:0] shape_gain(input logic [N-1:0] q,
                                                      input logic den_zero);
    if (den_zero)
      return UNITY;
    else if (|q[N-1:GAIN_BITS])
      return '1;
    else
      return q[GAIN_BITS-1:0];
  endfunction

  assign accept = (state == IDLE) && in_done;

  // State register.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; frame strobes outside IDLE are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_done)  state_nxt = DIV_R;
      DIV_R:   if (div_done) state_nxt = DIV_B;
      DIV_B:   if (div_done) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divider operands: R division kicked off the cycle after acceptance,
  // B division chained in the same cycle the R result comes out.
  always_comb begin
    div_start = div_kick || ((state == DIV_R) && div_done);
    div_num   = {hold_g, {GAIN_FRAC{1'b0}}};
    div_den   = div_kick ? {{GAIN_FRAC{1'b0}}, hold_r} : {{GAIN_FRAC{1'b0}}, hold_b};
  end

  isp_div_seq #(
    .WIDTH (N)
  ) u_div (
    .pclk  (pclk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .quot  (div_quot),
    .done  (div_done)
  );

  // Holding registers, quotient capture and published gains.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hold_cnt   <= '0;
      hold_r     <= '0;
      hold_g     <= '0;
      hold_b     <= '0;
      new_gain_r <= UNITY;
      new_gain_b <= UNITY;
      div_kick   <= 1'b0;
      out_gain_r <= UNITY;
      out_gain_b <= UNITY;
      out_valid  <= 1'b0;
      out_skip   <= 1'b0;
    end else begin
      div_kick  <= accept;
      out_valid <= 1'b0;
      out_skip  <= 1'b0;
      if (accept) begin
        hold_cnt <= in_cnt;
        hold_r   <= in_sum_r;
        hold_g   <= in_sum_g;
        hold_b   <= in_sum_b;
      end
      if ((state == DIV_R) && div_done)
        new_gain_r <= shape_gain(div_quot, hold_r == '0);
      if ((state == DIV_B) && div_done)
        new_gain_b <= shape_gain(div_quot, hold_b == '0);
      if (state == UPDATE) begin
        out_valid <= 1'b1;
        if (hold_cnt < OUT_BITS'(MIN_CNT)) begin
          out_skip <= 1'b1;
        end else if (enable) begin
          out_gain_r <= new_gain_r;
          out_gain_b <= new_gain_b;
        end else begin
          out_gain_r <= UNITY;
          out_gain_b <= UNITY;
        end
      end
    end
  end

  assign busy = (state != IDLE) || out_valid;

endmodule

// File: tb/tb_isp_awb_gain.sv
// tb/tb_isp_awb_gain.sv - self-checking bench for isp_awb_gain
module tb_isp_awb_gain;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        in_done = 1'b0;
  logic [31:0] in_cnt = '0;
  logic [31:0] in_sum_r = '0;
  logic [31:0] in_sum_g = '0;
  logic [31:0] in_sum_b = '0;
  logic [7:0]  out_gain_r;
  logic [7:0]  out_gain_b;
  logic        out_valid;
  logic        out_skip;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;
  longint mdl_r = 16;
  longint mdl_b = 16;

  isp_awb_gain dut (
    .pclk       (pclk),
    .rst        (rst),
    .enable     (enable),
    .in_done    (in_done),
    .in_cnt     (in_cnt),
    .in_sum_r   (in_sum_r),
    .in_sum_g   (in_sum_g),
    .in_sum_b   (in_sum_b),
    .out_gain_r (out_gain_r),
    .out_gain_b (out_gain_b),
    .out_valid  (out_valid),
    .out_skip   (out_skip),
    .busy       (busy)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic longint ref_gain(input longint g, input longint d);
    longint q;
    if (d == 0) return 16;
    q = (g * 16) / d;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Send one frame, wait for the result, compare against the gray-world model.
  task automatic run_frame(input string tag, input longint cnt, input longint r,
                           input longint g, input longint b);
    int  lat;
    logic exp_skip;
    in_cnt   = 32'(cnt);
    in_sum_r = 32'(r);
    in_sum_g = 32'(g);
    in_sum_b = 32'(b);
    in_done  = 1'b1;
    lat = 0;
    do begin
      step();
      in_done = 1'b0;
      lat++;
    end while (!out_valid && lat < 200);
    exp_skip = (cnt < 1024);
    if (!exp_skip) begin
      mdl_r = enable ? ref_gain(g, r) : 16;
      mdl_b = enable ? ref_gain(g, b) : 16;
    end
    check({tag, "_latency"}, lat, 77);
    check({tag, "_skip"}, out_skip, exp_skip);
    check({tag, "_gain_r"}, out_gain_r, mdl_r);
    check({tag, "_gain_b"}, out_gain_b, mdl_b);
    step();
    check({tag, "_pulse"}, out_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  function automatic longint rand_sum();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return longint'($urandom_range(1, 5000));
      2:       return longint'($urandom_range(5000, 2000000));
      default: return longint'($urandom);
    endcase
  endfunction

  initial begin
    int vcount;
    longint cr, cg, cb, cc;

    repeat (3) step();
    check("reset_gain_r", out_gain_r, 16);
    check("reset_gain_b", out_gain_b, 16);
    check("reset_valid", out_valid, 0);
    check("reset_skip", out_skip, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (2) step();

    enable = 1'b1;
    run_frame("nominal", 5000, 1000, 2000, 4000);
    check("nominal_const_r", out_gain_r, 32);
    check("nominal_const_b", out_gain_b, 8);

    run_frame("satzero", 5000, 10, 10000, 0);
    check("satzero_const_r", out_gain_r, 255);
    check("satzero_const_b", out_gain_b, 16);

    run_frame("nominal2", 5000, 1000, 2000, 4000);
    run_frame("mincnt", 1023, 500, 500, 500);
    check("mincnt_hold_r", out_gain_r, 32);
    check("mincnt_hold_b", out_gain_b, 8);
    run_frame("mincnt_edge", 1024, 500, 500, 500);
    check("mincnt_edge_r", out_gain_r, 16);

    enable = 1'b0;
    run_frame("disabled", 5000, 1000, 2000, 4000);
    check("disabled_r", out_gain_r, 16);
    enable = 1'b1;
    run_frame("reenabled", 5000, 1000, 2000, 4000);
    check("reenabled_b", out_gain_b, 8);

    // Second strobe while busy must be dropped.
    run_frame("pre_drop", 5000, 500, 500, 500);
    in_cnt = 32'd5000; in_sum_r = 32'd1000; in_sum_g = 32'd2000; in_sum_b = 32'd4000;
    in_done = 1'b1;
    vcount = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      in_done = 1'b0;
      if (k == 5) check("drop_busy_high", busy, 1);
      if (k == 10) begin
        in_sum_r = 32'd7000; in_sum_g = 32'd7000; in_sum_b = 32'd7000;
        in_done = 1'b1;
      end
      if (out_valid) begin
        vcount++;
        check("drop_gain_r", out_gain_r, 32);
        check("drop_gain_b", out_gain_b, 8);
      end
    end
    mdl_r = 32; mdl_b = 8;
    check("drop_valid_count", vcount, 1);
    run_frame("after_drop", 5000, 7000, 7000, 7000);

    // Reset in the middle of a division.
    run_frame("pre_reset", 5000, 1000, 2000, 4000);
    in_done = 1'b1;
    step();
    in_done = 1'b0;
    repeat (29) step();
    rst = 1'b1;
    #1;
    check("midrst_gain_r", out_gain_r, 16);
    check("midrst_gain_b", out_gain_b, 16);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    step();
    rst = 1'b0;
    mdl_r = 16; mdl_b = 16;
    vcount = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (out_valid) vcount++;
    end
    check("midrst_no_valid", vcount, 0);
    run_frame("post_reset", 5000, 1000, 2000, 4000);

    // Randomised frames against the model.
    for (int i = 0; i < 10; i++) begin
      cc = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 1100))
                                       : longint'($urandom_range(1024, 200000));
      cr = rand_sum();
      cg = rand_sum();
      cb = rand_sum();
      enable = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rand%0d", i), cc, cr, cg, cb);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
